// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : input_debouncer
// Purpose  : Conditions one raw, asynchronous, bouncy input (push-button or
//            switch) into a clean registered level plus single-cycle rise and
//            fall pulses. A two-flop synchronizer feeds a four-state
//            stability FSM. A saturating counter records rejected transitions
//            for debug visibility.
// Ports    : clk            - single clock, all state changes on rising edge
//            async_reset_n  - asynchronous active-low reset
//            raw_in         - asynchronous raw input
//            level          - debounced level (registered)
//            rise_pulse     - one-cycle pulse when level goes 0->1
//            fall_pulse     - one-cycle pulse when level goes 1->0
//            glitch_cnt     - rejected transitions, saturates at 255
// Revision : 1.0 - initial release
// ============================================================================
module input_debouncer #(
    parameter int   DEBOUNCE_CYCLES = 16,   // legal range 1..2^CNT_W
    parameter int   CNT_W           = 8,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic       clk,
    input  logic       async_reset_n,
    input  logic       raw_in,
    output logic       level,
    output logic       rise_pulse,
    output logic       fall_pulse,
    output logic [7:0] glitch_cnt
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    localparam state_t           c_RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;
    // Last count value before acceptance; DEBOUNCE_CYCLES-1 always fits in CNT_W.
    localparam logic [CNT_W-1:0] c_CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]       c_GLITCH_MAX  = 8'hFF;

    logic             sync1_q;
    logic             sync2_q;
    state_t           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             level_q,  level_d;
    logic             rise_q,   rise_d;
    logic             fall_q,   fall_d;
    logic [7:0]       glitch_q, glitch_d;
    logic [7:0]       w_glitch_inc;

    // Saturating increment: holds at 255 once reached.
    assign w_glitch_inc = (glitch_q == c_GLITCH_MAX) ? glitch_q : glitch_q + 8'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        glitch_d = glitch_q;
        case (state_q)
            STABLE_LO: begin
                if (sync2_q) begin
                    state_d = WAIT_HI;
                    cnt_d   = '0;
                end
            end
            WAIT_HI: begin
                if (!sync2_q) begin
                    // Input fell back before qualifying: reject it.
                    state_d  = STABLE_LO;
                    cnt_d    = '0;
                    glitch_d = w_glitch_inc;
                end else if (cnt_q == c_CNT_LAST) begin
                    state_d = STABLE_HI;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STABLE_HI: begin
                if (!sync2_q) begin
                    state_d = WAIT_LO;
                    cnt_d   = '0;
                end
            end
            WAIT_LO: begin
                if (sync2_q) begin
                    state_d  = STABLE_HI;
                    cnt_d    = '0;
                    glitch_d = w_glitch_inc;
                end else if (cnt_q == c_CNT_LAST) begin
                    state_d = STABLE_LO;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = c_RESET_STATE;
                cnt_d   = '0;
                level_d = RESET_LEVEL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            sync1_q  <= RESET_LEVEL;
            sync2_q  <= RESET_LEVEL;
            state_q  <= c_RESET_STATE;
            cnt_q    <= '0;
            level_q  <= RESET_LEVEL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= 8'd0;
        end else begin
            sync1_q  <= raw_in;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
        end
    end

    assign level      = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign glitch_cnt = glitch_q;

endmodule
`default_nettype wire

// File: tb/tb_input_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_debouncer
// Purpose  : Self-checking bench for input_debouncer (DEBOUNCE_CYCLES=4).
//            A driver applies directed and random raw_in patterns, runs a
//            run-length reference model and queues the expected outputs; a
//            monitor pops and compares after every rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_input_debouncer;

    localparam int C_DEB = 4;

    logic       clk = 1'b0;
    logic       async_reset_n = 1'b0;
    logic       raw_in = 1'b0;
    logic       level;
    logic       rise_pulse;
    logic       fall_pulse;
    logic [7:0] glitch_cnt;

    input_debouncer #(
        .DEBOUNCE_CYCLES(C_DEB),
        .CNT_W          (8),
        .RESET_LEVEL    (1'b0)
    ) dut (
        .clk          (clk),
        .async_reset_n(async_reset_n),
        .raw_in       (raw_in),
        .level        (level),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .glitch_cnt   (glitch_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       lvl;
        logic       rise;
        logic       fall;
        logic [7:0] g;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: raw_in reaches the decision point two edges later;
    // a new value is accepted once it has been seen for C_DEB+1 consecutive
    // samples, and any earlier return counts as a rejected glitch.
    logic m_pipe[2];   // [0] = one edge old, [1] = two edges old
    logic m_lvl;
    int   m_run;
    int   m_glitch;

    task automatic model_reset();
        m_pipe[0] = 1'b0;
        m_pipe[1] = 1'b0;
        m_lvl     = 1'b0;
        m_run     = 0;
        m_glitch  = 0;
    endtask

    // Drive one cycle (inputs change at the falling edge) and queue the
    // outputs expected just after the following rising edge.
    task automatic step(input logic r, input logic rst_n);
        exp_t e;
        logic s;
        @(negedge clk);
        raw_in        = r;
        async_reset_n = rst_n;
        e = '0;
        if (!rst_n) begin
            model_reset();
        end else begin
            s         = m_pipe[1];
            m_pipe[1] = m_pipe[0];
            m_pipe[0] = r;
            if (s != m_lvl) begin
                m_run++;
                if (m_run == C_DEB + 1) begin
                    m_lvl  = s;
                    e.rise = s;
                    e.fall = ~s;
                    m_run  = 0;
                end
            end else if (m_run > 0) begin
                m_run = 0;
                if (m_glitch < 255) m_glitch++;
            end
        end
        e.lvl = m_lvl;
        e.g   = 8'(m_glitch);
        exp_q.push_back(e);
    endtask

    task automatic check1(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, req);
        end
    endtask

    // Monitor: compare once per edge, away from the edge itself.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check1("level",      int'(level),      int'(e.lvl));
            check1("rise_pulse", int'(rise_pulse), int'(e.rise));
            check1("fall_pulse", int'(fall_pulse), int'(e.fall));
            check1("glitch_cnt", int'(glitch_cnt), int'(e.g));
            check1("pulse_excl", int'(rise_pulse & fall_pulse), 0);
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();

        // Reset held with raw_in toggling, then release with raw_in low.
        for (int i = 0; i < 10; i++) step(1'($urandom_range(0, 1)), 1'b0);
        repeat (50) step(1'b0, 1'b1);

        // Clean rise then clean fall.
        repeat (12) step(1'b1, 1'b1);
        repeat (12) step(1'b0, 1'b1);

        // Short high (3 cycles) rejected as a glitch.
        repeat (3)  step(1'b1, 1'b1);
        repeat (10) step(1'b0, 1'b1);

        // Bounce then settle high.
        step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1);
        step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1);
        repeat (12) step(1'b1, 1'b1);

        // Back-to-back reversal right after acceptance.
        repeat (C_DEB + 3) step(1'b0, 1'b1);
        repeat (C_DEB + 3) step(1'b1, 1'b1);
        repeat (12) step(1'b0, 1'b1);

        // Random runs of varying length straddling the acceptance threshold.
        for (int i = 0; i < 400; i++) begin
            logic v;
            int   len;
            v   = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 2 * C_DEB + 2));
            for (int j = 0; j < len; j++) step(v, 1'b1);
        end

        // Saturation: 300 single-cycle glitches from a settled low level.
        repeat (12) step(1'b0, 1'b1);
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 1'b1);
            step(1'b0, 1'b1);
            step(1'b0, 1'b1);
        end
        repeat (10) step(1'b0, 1'b1);

        // Reset in the middle of a pending rise, raw_in stays high.
        step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1);
        repeat (3) step(1'b1, 1'b0);
        repeat (C_DEB + 8) step(1'b1, 1'b1);

        // Let the monitor drain the queue, with a bound.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        check1("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/input_debouncer.md
# input_debouncer

Conditions one raw, asynchronous, bouncy input (push-button or switch) into a clean single-bit level and single-cycle edge pulses. It sits directly upstream of the single-bit data flops (D/sync_reset register stage), whose D or sync_reset pins it drives. It has a two-flop synchronizer, a stability counter with a four-state FSM, and a saturating glitch counter for debug.

## Interface
- DEBOUNCE_CYCLES, 16, consecutive synchronized cycles the new value must hold before it is accepted; legal range 1..2^CNT_W
- CNT_W, 8, width of the stability counter
- RESET_LEVEL, 1'b0, value of synchronizer flops and `level` out of reset
- clk  input  1  single clock; all state changes on rising edge
- async_reset_n  input  1  asynchronous, active-low reset; assertion clears immediately, deassertion is synchronous to clk by the system
- raw_in  input  1  asynchronous raw input
- level  output  1  debounced level (registered)
- rise_pulse  output  1  one-cycle pulse when `level` goes 0→1 (registered)
- fall_pulse  output  1  one-cycle pulse when `level` goes 1→0 (registered)
- glitch_cnt  output  8  count of rejected transitions, saturates at 255

## Operation
- Synchronizer: sync1 <= raw_in; sync2 <= sync1. Only sync2 is used downstream.
- FSM states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO. `level` = 0 in STABLE_LO/WAIT_HI and 1 in STABLE_HI/WAIT_LO.
- STABLE_LO: if sync2==1, go to WAIT_HI with cnt=0. Otherwise stay.
- WAIT_HI:
  - sync2==0: glitch. Go to STABLE_LO, cnt=0, glitch_cnt++ (saturating).
  - sync2==1 and cnt==DEBOUNCE_CYCLES-1: go to STABLE_HI, level<=1, rise_pulse<=1, cnt=0.
  - Otherwise cnt<=cnt+1.
- STABLE_HI and WAIT_LO mirror the above with polarity swapped. Acceptance in WAIT_LO sets fall_pulse.
- Pulses are high for exactly one cycle. rise_pulse and fall_pulse are never high together.
- Counter arithmetic is unsigned CNT_W bits. It never exceeds DEBOUNCE_CYCLES-1, so no wrap.
- glitch_cnt holds at 255 once reached. It is cleared only by reset.
- Reset values:
  - sync1 = sync2 = RESET_LEVEL
  - state = STABLE_HI if RESET_LEVEL else STABLE_LO
  - cnt = 0, level = RESET_LEVEL
  - rise_pulse = fall_pulse = 0, glitch_cnt = 0
- Reset mid-wait: the pending transition is discarded. No pulse is emitted during or after reset unless a full new qualification completes.
- DEBOUNCE_CYCLES=1: acceptance occurs on the first WAIT cycle in which sync2 still holds the new value.

## Timing
- Latency: raw_in changes and is held before edge 0.
  - sync1 captures it at edge 0, sync2 at edge 1.
  - WAIT is entered at edge 2.
  - level and pulse update at edge 2+DEBOUNCE_CYCLES.
  - Total latency is DEBOUNCE_CYCLES+2 rising edges.
- Rejection: a deviation must reach sync2 and then return before acceptance. A returned value seen in WAIT causes the return to STABLE on that same edge.
- Pulse-free bounce: any sync2 pattern that never holds the new value for DEBOUNCE_CYCLES+1 consecutive sync2 samples produces no level change.
- Back-to-back toggles: after acceptance, FSM is in STABLE. A reverse transition visible in sync2 on the next cycle enters the opposite WAIT one edge later. Minimum spacing between opposite pulses is DEBOUNCE_CYCLES+1 cycles.
- Outputs are glitch-free registers. Downstream may sample them directly on clk.

## Test plan
- Reset: hold async_reset_n=0 with raw_in toggling, RESET_LEVEL=0 → level=0, pulses=0, glitch_cnt=0 throughout. Release with raw_in=0 → no pulse for 50 cycles.
- Clean rise, DEBOUNCE_CYCLES=4: raw_in 0→1 before edge 0 and held → level=1 and rise_pulse=1 at edge 6 only. rise_pulse=0 at edge 7.
- Glitch rejection, DEBOUNCE_CYCLES=4: raw_in high for 3 cycles then low → level stays 0, no pulses, glitch_cnt=1.
- Bounce then settle: raw_in pattern 1,0,1,1,0,1 then held 1 → glitch_cnt=2. Exactly one rise_pulse, 6 edges after the final sync2 transition to 1 enters WAIT-2.
- Saturation: 300 rejected glitches → glitch_cnt=255 and holds.
- Reset mid-wait: raw_in 0→1, assert async_reset_n after 3 cycles, release, raw_in still 1 → no pulse during reset. rise_pulse occurs DEBOUNCE_CYCLES+2 edges after release.
